ts_capture_unit: RTL

//  Parametrised free-running timestamp counter with software load and N_CH hardware event-capture channels.

---
 rtl/ts_capture_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ts_capture_unit.sv
// Free-running timestamp with software load and N_CH event-capture channels.
// Each channel latches the timestamp on a synchronised rising edge of its event input.
`timescale 1ns/1ps
module ts_capture_unit #(
    parameter int TS_W     = 64,
    parameter int TICK_DIV = 50,
    parameter int TICK_INC = 4295,
    parameter int N_CH     = 4
) (
    input  logic                 i_clk_50m,
    input  logic                 i_rst_n,
    input  logic                 i_ts_load,
    input  logic [TS_W-1:0]      i_ts_set,
    output logic [TS_W-1:0]      o_ts_now,
    output logic                 o_tick,
    input  logic [N_CH-1:0]      i_evt,
    input  logic [N_CH-1:0]      i_cap_en,
    output logic [N_CH*TS_W-1:0] o_cap_ts,
    output logic [N_CH-1:0]      o_cap_vld,
    input  logic [N_CH-1:0]      i_cap_ack,
    output logic [N_CH-1:0]      o_cap_ovr,
    input  logic [N_CH-1:0]      i_ovr_clr
);

    localparam int              DIV_W   = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [TS_W-1:0]  INC     = TS_W'(TICK_INC);

    logic [DIV_W-1:0] r_div;
    logic [TS_W-1:0]  r_ts;
    logic             w_wrap;
    logic             w_tick;

    logic [N_CH-1:0]  r_sync1;
    logic [N_CH-1:0]  r_sync2;
    logic [N_CH-1:0]  r_prev;
    logic [N_CH-1:0]  r_vld;
    logic [N_CH-1:0]  r_ovr;
    logic [TS_W-1:0]  r_cap [N_CH];

    logic [N_CH-1:0]  w_edge;
    logic [N_CH-1:0]  w_vld_nxt;
    logic [N_CH-1:0]  w_lat;
    logic [N_CH-1:0]  w_ovr_set;

    assign w_wrap = (r_div == DIV_MAX);
    assign w_tick = w_wrap & ~i_ts_load;

    // Divider and timestamp: load beats a coincident tick and restarts the divider
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
            r_ts  <= '0;
        end else if (i_ts_load) begin
            r_div <= '0;
            r_ts  <= i_ts_set;
        end else if (w_wrap) begin
            r_div <= '0;
            r_ts  <= r_ts + INC;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Two-stage synchroniser plus previous-level register for edge detection
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_evt;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_prev & i_cap_en;

    // Per-channel IDLE/FULL state register
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= w_vld_nxt;
        end
    end

    // Next state: an edge always leaves the channel FULL, an ack alone empties it
    always_comb begin
        w_vld_nxt = r_vld;
        for (int c = 0; c < N_CH; c++) begin
            unique case (r_vld[c])
                1'b0: w_vld_nxt[c] = w_edge[c];
                1'b1: w_vld_nxt[c] = w_edge[c] | ~i_cap_ack[c];
            endcase
        end
    end

    // Outputs of the channel FSM: latch strobe and overrun strobe
    always_comb begin
        w_lat     = w_edge & (~r_vld | i_cap_ack);
        w_ovr_set = w_edge & r_vld & ~i_cap_ack;
    end

    // Capture registers hold the timestamp seen in the edge cycle
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                r_cap[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_lat[c]) begin
                    r_cap[c] <= r_ts;
                end
            end
        end
    end

    // Sticky overrun: a set in the same cycle as a clear wins
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovr <= '0;
        end else begin
            r_ovr <= w_ovr_set | (r_ovr & ~i_ovr_clr);
        end
    end

    // Flatten capture registers onto the output bus
    always_comb begin
        o_cap_ts = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_cap_ts[c*TS_W +: TS_W] = r_cap[c];
        end
    end

    assign o_ts_now  = r_ts;
    assign o_tick    = w_tick;
    assign o_cap_vld = r_vld;
    assign o_cap_ovr = r_ovr;

endmodule
